instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000000, SHALL be the instruction word driven on if_id_instr when no valid instruction is held.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 pc  input  32  SHALL carry the current instruction address from the program counter register.
REQ-005 pc_write  output  1  SHALL be the write enable for the program counter register.
REQ-006 stall_id  input  1  SHALL mean decode cannot accept a new instruction this cycle.
REQ-007 flush  input  1  SHALL mean a taken branch or jump; in-flight fetch is discarded.
REQ-008 mem_req  output  1  SHALL request an instruction memory read.
REQ-009 mem_addr  output  32  SHALL be the word-aligned read address.
REQ-010 mem_ack  input  1  SHALL mean mem_rdata is valid this cycle.
REQ-011 mem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 if_id_instr, if_id_pc, if_id_pc4  outputs  32 each  SHALL form the IF/ID register: instruction, its address, and its address + 4.
REQ-013 if_id_valid  output  1  SHALL flag that the IF/ID register holds a real instruction.

Function
REQ-014 FSM states SHALL be ISSUE, REQ and HOLD; internal registers SHALL be req_addr (32), hold_instr (32) and kill (1).
REQ-015 In ISSUE with flush=0: req_addr <= pc, next state REQ; with flush=1: remain in ISSUE and leave req_addr unchanged.
REQ-016 In REQ: mem_req=1 and mem_addr={req_addr[31:2],2'b00}; in ISSUE and HOLD: mem_req=0 and mem_addr=0.
REQ-017 In REQ with mem_ack=1, flush=0, kill=0 and stall_id=0, the block SHALL:
- load if_id_instr<=mem_rdata, if_id_pc<=req_addr, if_id_pc4<=req_addr+4 and if_id_valid<=1;
- assert pc_write=1 in the same cycle;
- go to ISSUE.
REQ-018 In REQ with mem_ack=1, flush=0, kill=0 and stall_id=1: hold_instr<=mem_rdata, pc_write=0, go to HOLD; IF/ID unchanged.
REQ-019 In HOLD with stall_id=0 and flush=0: load IF/ID from hold_instr and req_addr as in REQ-017, pc_write=1, go to ISSUE; while stall_id=1, remain in HOLD.
REQ-020 pc_write SHALL be combinational, asserted only as in REQ-017, REQ-019 and REQ-022, and 0 otherwise.
REQ-021 When stall_id=1 and flush=0, all IF/ID outputs SHALL hold their values; when stall_id=0 and no instruction is loaded that cycle, if_id_valid<=0 and if_id_instr<=NOP_INSTR.
REQ-022 flush=1 SHALL override stall_id and SHALL:
- assert pc_write=1 so the PC loads the target;
- set if_id_valid<=0 and if_id_instr<=NOP_INSTR;
- from HOLD, go to ISSUE.
REQ-023 flush=1 in REQ without mem_ack SHALL set kill<=1 and remain in REQ; flush=1 in REQ with mem_ack=1 SHALL discard mem_rdata and go to ISSUE.
REQ-024 In REQ with kill=1, mem_ack=1 SHALL discard mem_rdata, clear kill, go to ISSUE, and assert pc_write only if flush=1.
REQ-025 mem_ack while in ISSUE or HOLD SHALL be ignored.
REQ-026 if_id_pc4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); pc[1:0] SHALL be ignored for addressing but preserved in if_id_pc.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles with a zero-wait-state memory.

Reset
REQ-028 reset=0 SHALL immediately force the following, independent of clk:
- state to ISSUE, with req_addr, hold_instr and kill cleared;
- mem_req=0, mem_addr=0, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0 and if_id_pc4=0.
REQ-029 pc_write SHALL be 0 while reset=0.
REQ-030 An outstanding memory request SHALL be abandoned at reset, and any mem_ack arriving after release SHALL be ignored until the block next enters REQ.

Verification
REQ-031 Release reset with pc=0x00400000 and mem_ack=1 returning 0x20080005 in the same cycle -> if_id_instr=0x20080005, if_id_pc=0x00400000, if_id_pc4=0x00400004, pc_write pulsed 1 cycle, mem_req high exactly 1 cycle.
REQ-032 stall_id=1 when mem_ack arrives, held 3 cycles -> no pc_write while stalled; HOLD state held; after release, if_id_instr=fetched word, pc_write=1 for 1 cycle.
REQ-033 flush in REQ 2 cycles before a delayed mem_ack -> kill set, acked word discarded, if_id_valid=0, next mem_addr equals the new pc.
REQ-034 pc=0xFFFFFFFC fetched -> if_id_pc4=0x00000000; pc=0x00400006 -> mem_addr=0x00400004 and if_id_pc=0x00400006.
REQ-035 reset asserted mid-REQ, then a mem_ack arrives after release -> all outputs at reset values, stale ack ignored, first fetch uses the post-reset pc.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read per instruction and fills the IF/ID register.
// Latency: an instruction reaches IF/ID two cycles after the PC is sampled with a zero-wait memory.
// Backpressure: stall_id parks a returned word in HOLD; flush overrides the stall and kills any read in flight.
module instr_fetch #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_write,
  input  logic        stall_id,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        load;
  logic [31:0] load_instr;
  logic        pc_write_c;

  // Next-state, memory request and PC write-enable decode.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    hold_instr_d = hold_instr_q;
    kill_d       = kill_q;
    load         = 1'b0;
    load_instr   = mem_rdata;
    pc_write_c   = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = 32'h0;
    case (state_q)
      ISSUE: begin
        if (flush) begin
          pc_write_c = 1'b1;
        end else begin
          req_addr_d = pc;
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr_q[31:2], 2'b00};
        if (flush) begin
          pc_write_c = 1'b1;
          if (mem_ack) begin
            // The killed read (old or current) has returned; drop it.
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            // Read still in flight: remember to discard its data.
            kill_d = 1'b1;
          end
        end else if (mem_ack) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = ISSUE;
          end else if (!stall_id) begin
            load       = 1'b1;
            pc_write_c = 1'b1;
            state_d    = ISSUE;
          end else begin
            hold_instr_d = mem_rdata;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_write_c = 1'b1;
          state_d    = ISSUE;
        end else if (!stall_id) begin
          load       = 1'b1;
          load_instr = hold_instr_q;
          pc_write_c = 1'b1;
          state_d    = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // IF/ID register update: flush clears, a delivered word loads, a free decode drains to a bubble.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_instr;
      pc_d    = req_addr_q;
      pc4_d   = req_addr_q + 32'd4;
      valid_d = 1'b1;
    end else if (!stall_id) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // State and IF/ID registers; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ISSUE;
      req_addr_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      kill_q       <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      kill_q       <= kill_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  // The PC must never load while reset is held, even if flush is high.
  assign pc_write    = pc_write_c & reset;
  assign if_id_instr = instr_q;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch/stall/flush/reset scenarios.
// A transaction-level model predicts every output each cycle; literal checks pin key values.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_write;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid;

  instr_fetch #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_write(pc_write),
    .stall_id(stall_id), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy: a read is being presented; parked: a word waits for decode; drop: next ack is stale.
  logic        m_busy = 1'b0, m_parked = 1'b0, m_drop = 1'b0, m_valid = 1'b0;
  logic [31:0] m_addr = 32'h0, m_word = 32'h0;
  logic [31:0] m_instr = NOP, m_pc = 32'h0, m_pc4 = 32'h0;

  wire        m_idle    = !m_busy && !m_parked;
  wire        m_take    = m_busy && mem_ack && !m_drop;
  wire        m_deliver = !flush && !stall_id && (m_take || m_parked);
  wire [31:0] m_dword   = m_parked ? m_word : mem_rdata;
  wire        exp_pcw   = reset && (flush || m_deliver);
  wire [31:0] exp_maddr = m_busy ? (m_addr & 32'hFFFF_FFFC) : 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_parked <= 1'b0; m_drop <= 1'b0;
      m_addr <= 32'h0; m_word <= 32'h0;
      m_valid <= 1'b0; m_instr <= NOP; m_pc <= 32'h0; m_pc4 <= 32'h0;
    end else if (flush) begin
      m_valid  <= 1'b0;
      m_instr  <= NOP;
      m_parked <= 1'b0;
      if (m_busy) begin
        if (mem_ack) begin
          m_busy <= 1'b0;
          m_drop <= 1'b0;
        end else begin
          m_drop <= 1'b1;
        end
      end
    end else begin
      if (m_idle) begin
        m_busy <= 1'b1;
        m_addr <= pc;
      end
      if (m_busy && mem_ack) begin
        m_busy <= 1'b0;
        m_drop <= 1'b0;
        if (m_take && stall_id) begin
          m_parked <= 1'b1;
          m_word   <= mem_rdata;
        end
      end
      if (m_parked && !stall_id) m_parked <= 1'b0;
      if (m_deliver) begin
        m_valid <= 1'b1;
        m_instr <= m_dword;
        m_pc    <= m_addr;
        m_pc4   <= m_addr + 32'd4;
      end else if (!stall_id) begin
        m_valid <= 1'b0;
        m_instr <= NOP;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req",     {31'h0, mem_req},     {31'h0, m_busy});
      chk("mem_addr",    mem_addr,             exp_maddr);
      chk("pc_write",    {31'h0, pc_write},    {31'h0, exp_pcw});
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
      chk("if_id_instr", if_id_instr,          m_instr);
      chk("if_id_pc",    if_id_pc,             m_pc);
      chk("if_id_pc4",   if_id_pc4,            m_pc4);
    end
  end

  // ---------------- stimulus ----------------
  int          pcw_cnt = 0;
  int          mreq_cnt = 0;
  logic [31:0] last_maddr = 32'h0;
  logic        last_pcw = 1'b0;

  task automatic step(input logic fl, input logic st, input logic ak, input logic [31:0] rd);
    flush = fl; stall_id = st; mem_ack = ak; mem_rdata = rd;
    @(negedge clk);
    last_pcw   = pc_write;
    last_maddr = mem_addr;
    pcw_cnt   += int'(pc_write);
    mreq_cnt  += int'(mem_req);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with flush high: pc_write must stay low.
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc_write", {31'h0, pc_write}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'hAAAA_AAAA);
    chk("rst_pcw_flush", {31'h0, last_pcw}, 32'h0);

    // First fetch straight out of reset, ack held high throughout.
    reset = 1'b1; pc = 32'h0040_0000;
    pcw_cnt = 0; mreq_cnt = 0;
    step(1'b0, 1'b0, 1'b1, 32'h2008_0005);
    step(1'b0, 1'b0, 1'b1, 32'h2008_0005);
    chk("f1_instr", if_id_instr, 32'h2008_0005);
    chk("f1_pc",    if_id_pc,    32'h0040_0000);
    chk("f1_pc4",   if_id_pc4,   32'h0040_0004);
    chk("f1_valid", {31'h0, if_id_valid}, 32'h1);
    pc = 32'h0040_0004;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("f1_pcw_pulses", pcw_cnt, 1);
    chk("f1_mreq_cycles", mreq_cnt, 1);

    // Stall when the ack arrives, held for three cycles.
    pcw_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 32'h1111_1111);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_no_pcw", pcw_cnt, 0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_rel_pcw", {31'h0, last_pcw}, 32'h1);
    chk("stall_instr", if_id_instr, 32'h1111_1111);
    chk("stall_pc4",   if_id_pc4,   32'h0040_0008);

    // Flush two cycles before a delayed ack.
    pc = 32'h0040_0008;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("kill_pcw", {31'h0, last_pcw}, 32'h1);
    pc = 32'h0050_0000;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("kill_valid", {31'h0, if_id_valid}, 32'h0);
    chk("kill_instr", if_id_instr, NOP);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("kill_newaddr", last_maddr, 32'h0050_0000);
    step(1'b0, 1'b0, 1'b1, 32'h2222_2222);
    chk("kill_refetch", if_id_instr, 32'h2222_2222);

    // PC+4 wrap and unaligned PC.
    pc = 32'hFFFF_FFFC;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h3333_3333);
    chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
    pc = 32'h0040_0006;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h4444_4444);
    chk("unal_maddr", last_maddr, 32'h0040_0004);
    chk("unal_pc",    if_id_pc,   32'h0040_0006);

    // Flush coinciding with the ack in REQ.
    pc = 32'h0000_0100;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h5555_5555);
    chk("flack_valid", {31'h0, if_id_valid}, 32'h0);

    // Flush overriding a stall while parked in HOLD.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h6666_6666);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("flhold_pcw", {31'h0, last_pcw}, 32'h1);
    pc = 32'h0000_0200;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h7777_7777);
    chk("flhold_instr", if_id_instr, 32'h7777_7777);

    // Flush in ISSUE, then ack during the following ISSUE is ignored.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h9999_9999);
    step(1'b0, 1'b1, 1'b0, 32'h0);

    // Reset asserted mid-REQ, stale ack after release.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    chk("arst_mreq",  {31'h0, mem_req}, 32'h0);
    chk("arst_maddr", mem_addr, 32'h0);
    chk("arst_instr", if_id_instr, NOP);
    chk("arst_pc4",   if_id_pc4, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1; pc = 32'h0060_0000;
    step(1'b0, 1'b0, 1'b1, 32'hBADB_AD00);
    step(1'b0, 1'b0, 1'b1, 32'h8888_8888);
    chk("post_rst_instr", if_id_instr, 32'h8888_8888);
    chk("post_rst_pc",    if_id_pc,    32'h0060_0000);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is short; this only guards against a stuck run.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
